// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ifetch_pkg;

  // Two-phase fetch/execute sequencing.
  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // The ALU reports branch targets as word addresses; convert to a byte address.
  function automatic logic [31:0] word_to_byte(input logic [31:0] word_addr);
    return {word_addr[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory request/ack handshake.
// Latency: n/a (wires only). The ack may arrive in the same cycle as the request.
// Backpressure: memory stalls the fetcher by holding imem_ack low; the request stays stable meanwhile.
// Ports: imem_req/imem_addr (fetcher -> memory), imem_ack/imem_rdata (memory -> fetcher).
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetcher side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction-memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: picks the next PC from jr / jump / taken-branch / sequential targets.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is loaded.
// Ports: pc_plus_4_i, instr_i, addr_result_i, read_data_1_i, branch/nbranch/zero/jmp/jal/jr_i -> next_pc_o.
module pc_next_sel
  import ifetch_pkg::*;
(
  input  logic [31:0] pc_plus_4_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] addr_result_i,
  input  logic [31:0] read_data_1_i,
  input  logic        branch_i,
  input  logic        nbranch_i,
  input  logic        zero_i,
  input  logic        jmp_i,
  input  logic        jal_i,
  input  logic        jr_i,
  output logic [31:0] next_pc_o
);

  logic taken;

  always_comb begin
    taken = (branch_i & zero_i) | (nbranch_i & ~zero_i);
    // jr wins over jal, so jalr jumps to rs while the caller still updates the link.
    if (jr_i) begin
      next_pc_o = {read_data_1_i[31:2], 2'b00};
    end else if (jmp_i | jal_i) begin
      next_pc_o = {pc_plus_4_i[31:28], instr_i[25:0], 2'b00};
    end else if (taken) begin
      next_pc_o = word_to_byte(addr_result_i);
    end else begin
      next_pc_o = pc_plus_4_i;
    end
  end

  // Opcode bits, the top of the word target and the rs byte offset do not affect the PC.
  logic unused_bits;
  assign unused_bits = &{1'b0, instr_i[31:26], addr_result_i[31:30], read_data_1_i[1:0]};

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: two-state instruction fetcher (FETCH -> EXEC) with PC, link register and optional retire counter.
// Latency: 2 cycles per instruction minimum (one FETCH cycle with same-cycle ack, then one EXEC cycle).
// Backpressure: FETCH waits on imem_ack with the request held; stall freezes EXEC.
// Ports: clock/reset (sync, active high), imem (master handshake), ALU/decode inputs,
//        Instruction/instr_valid/PC_plus_4/link_addr/retired_cnt outputs.
// Build option: define IFETCH_PERF_EN to get a wrapping retired-instruction counter; otherwise retired_cnt reads 0.
module ifetch_unit
  import ifetch_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  ifetch_unit_if.master       imem,
  input  logic [31:0]         Addr_Result,
  input  logic                Zero,
  input  logic [31:0]         Read_data_1,
  input  logic                Branch,
  input  logic                nBranch,
  input  logic                Jmp,
  input  logic                Jal,
  input  logic                Jr,
  input  logic                stall,
  output logic [31:0]         Instruction,
  output logic                instr_valid,
  output logic [31:0]         PC_plus_4,
  output logic [31:0]         link_addr,
  output logic [31:0]         retired_cnt
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] link_q;
  logic [31:0] next_pc_d;
  logic        retire;

  assign PC_plus_4 = pc_q + PC_STEP;

  // The request is masked while reset is held so no fetch is issued during reset,
  // and rises as soon as reset drops because the state is already FETCH.
  assign imem.imem_req  = (state_q == FETCH) & ~reset;
  assign imem.imem_addr = pc_q;

  assign Instruction = instr_q;
  assign instr_valid = valid_q;
  assign link_addr   = link_q;

  assign retire = (state_q == EXEC) & ~stall;

  pc_next_sel u_pc_next_sel (
    .pc_plus_4_i   (PC_plus_4),
    .instr_i       (instr_q),
    .addr_result_i (Addr_Result),
    .read_data_1_i (Read_data_1),
    .branch_i      (Branch),
    .nbranch_i     (nBranch),
    .zero_i        (Zero),
    .jmp_i         (Jmp),
    .jal_i         (Jal),
    .jr_i          (Jr),
    .next_pc_o     (next_pc_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      link_q  <= '0;
    end else if (state_q == FETCH) begin
      // An ack is only meaningful here; in EXEC it is ignored.
      if (imem.imem_ack) begin
        instr_q <= imem.imem_rdata;
        valid_q <= 1'b1;
        state_q <= EXEC;
      end
    end else if (!stall) begin
      pc_q    <= next_pc_d;
      valid_q <= 1'b0;
      state_q <= FETCH;
      if (Jal) begin
        link_q <= PC_plus_4;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] retired_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = '0;

  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit.
// Expected fetch addresses and instructions are queued when stimulus is driven and
// compared when the unit issues the next request / presents the instruction.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr_Result = '0;
  logic        Zero = 1'b0;
  logic [31:0] Read_data_1 = '0;
  logic        Branch = 1'b0;
  logic        nBranch = 1'b0;
  logic        Jmp = 1'b0;
  logic        Jal = 1'b0;
  logic        Jr = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC_plus_4;
  logic [31:0] link_addr;
  logic [31:0] retired_cnt;

  ifetch_unit_if imem ();

  ifetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem),
    .Addr_Result (Addr_Result),
    .Zero        (Zero),
    .Read_data_1 (Read_data_1),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jr          (Jr),
    .stall       (stall),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .PC_plus_4   (PC_plus_4),
    .link_addr   (link_addr),
    .retired_cnt (retired_cnt)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] pc_m, link_m, ret_m, instr_m;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ret_exp();
`ifdef IFETCH_PERF_EN
    return ret_m;
`else
    return 32'd0;
`endif
  endfunction

  task automatic clear_dec();
    Branch = 0; nBranch = 0; Zero = 0; Jmp = 0; Jal = 0; Jr = 0;
    Addr_Result = '0; Read_data_1 = '0;
  endtask

  task automatic restart_model();
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_addr_q.push_back(RESET_PC);
    pc_m = RESET_PC; link_m = '0; ret_m = '0; instr_m = '0;
  endtask

  task automatic do_reset();
    reset = 1; stall = 0;
    imem.imem_ack = 0; imem.imem_rdata = '0;
    clear_dec();
    repeat (2) @(negedge clock);
    chk("rst_req",   imem.imem_req, 0);
    chk("rst_addr",  imem.imem_addr, RESET_PC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_link",  link_addr, 0);
    chk("rst_ret",   retired_cnt, 0);
    reset = 0;
    #1;
    chk("req_after_rst", imem.imem_req, 1);
    restart_model();
  endtask

  // Wait for the next request and pop/compare its address; leaves the unit in FETCH.
  task automatic expect_request(output bit ok);
    int cnt = 0;
    logic [31:0] ea;
    ok = 0;
    while (imem.imem_req !== 1'b1 && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    if (imem.imem_req !== 1'b1) begin
      chk("req_timeout", imem.imem_req, 1);
      return;
    end
    if (exp_addr_q.size() == 0) begin
      chk("sb_addr_empty", imem.imem_addr, 32'hFFFF_FFFF);
      return;
    end
    ea = exp_addr_q.pop_front();
    chk("fetch_addr", imem.imem_addr, ea);
    chk("pc_plus_4", PC_plus_4, ea + 32'd4);
    pc_m = ea;
    ok = 1;
  endtask

  task automatic fetch_one(input int waits, input logic [31:0] rdata);
    bit ok;
    expect_request(ok);
    if (!ok) return;
    for (int i = 0; i < waits; i++) begin
      imem.imem_ack = 0;
      @(negedge clock);
      chk("addr_hold",  imem.imem_addr, pc_m);
      chk("req_hold",   imem.imem_req, 1);
      chk("wait_valid", instr_valid, 0);
    end
    imem.imem_ack = 1;
    imem.imem_rdata = rdata;
    exp_instr_q.push_back(rdata);
    @(negedge clock);
    imem.imem_ack = 0;
    imem.imem_rdata = 32'hBAD0_BAD0;
    chk("valid_rise", instr_valid, 1);
    chk("req_drop",   imem.imem_req, 0);
    chk("instr",      Instruction, exp_instr_q.pop_front());
    instr_m = rdata;
  endtask

  task automatic exec_one(input int stalls, input logic br, input logic nbr, input logic z,
                          input logic jmp, input logic jal, input logic jr,
                          input logic [31:0] ar, input logic [31:0] rd1);
    logic [31:0] ppc, npc;
    Branch = br; nBranch = nbr; Zero = z; Jmp = jmp; Jal = jal; Jr = jr;
    Addr_Result = ar; Read_data_1 = rd1;
    chk("exec_pc4", PC_plus_4, pc_m + 32'd4);
    stall = 1;
    for (int i = 0; i < stalls; i++) begin
      // A stray ack while executing must not disturb anything.
      imem.imem_ack = 1;
      imem.imem_rdata = 32'hFFFF_0000 ^ i;
      @(negedge clock);
      chk("stall_instr", Instruction, instr_m);
      chk("stall_pc",    imem.imem_addr, pc_m);
      chk("stall_valid", instr_valid, 1);
    end
    imem.imem_ack = 0;
    stall = 0;
    ppc = pc_m + 32'd4;
    if (jr)                     npc = {rd1[31:2], 2'b00};
    else if (jmp || jal)        npc = {ppc[31:28], instr_m[25:0], 2'b00};
    else if ((br && z) || (nbr && !z)) npc = {ar[29:0], 2'b00};
    else                        npc = ppc;
    if (jal) link_m = ppc;
    ret_m = ret_m + 1;
    exp_addr_q.push_back(npc);
    @(negedge clock);
    clear_dec();
    chk("valid_fall", instr_valid, 0);
    chk("link",       link_addr, link_m);
    chk("retired",    retired_cnt, ret_exp());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    imem.imem_ack = 0;
    imem.imem_rdata = '0;
    do_reset();

    // First fetch with three wait cycles, then a run of sequential instructions.
    fetch_one(3, 32'h2008_0005); exec_one(0, 0,0,0, 0,0,0, 32'h0, 32'h0);        // -> 0x04
    fetch_one(0, 32'h0000_0020); exec_one(1, 0,0,0, 0,0,0, 32'h0, 32'h0);        // -> 0x08
    fetch_one(2, 32'h0000_0021); exec_one(0, 0,0,0, 0,0,0, 32'h0, 32'h0);        // -> 0x0C
    fetch_one(0, 32'h0000_0022); exec_one(0, 0,0,0, 0,0,0, 32'h0, 32'h0);        // -> 0x10
    // Branch taken / not taken from 0x10.
    fetch_one(1, 32'h1040_0002); exec_one(0, 1,0,1, 0,0,0, 32'h9, 32'h0);        // -> 0x24
    fetch_one(0, 32'h0200_0008); exec_one(0, 0,0,0, 0,0,1, 32'h0, 32'h10);       // jr -> 0x10
    fetch_one(0, 32'h1040_0002); exec_one(0, 1,0,0, 0,0,0, 32'h9, 32'h0);        // -> 0x14
    fetch_one(0, 32'h1440_0003); exec_one(0, 0,1,0, 0,0,0, 32'h10, 32'h0);       // bne -> 0x40
    // jal from 0x40.
    fetch_one(0, 32'h0C00_0100); exec_one(0, 0,0,0, 0,1,0, 32'h0, 32'h0);        // -> 0x400
    // jr after a 5-cycle stall; tenth retirement.
    fetch_one(0, 32'h0060_0008); exec_one(5, 0,0,0, 0,0,1, 32'h0, 32'h123);      // -> 0x120
    // Jump beats a taken branch.
    fetch_one(0, 32'h0BFF_FFFF); exec_one(0, 1,0,1, 1,0,0, 32'h5, 32'h0);        // -> 0x0FFFFFFC
    // jalr: jr target with link update, beats jal and branch.
    fetch_one(0, 32'h0C00_0001); exec_one(0, 1,0,1, 0,1,1, 32'h5, 32'hFFFF_FFFF); // -> 0xFFFFFFFC
    // Sequential wrap at the top of the address space.
    fetch_one(0, 32'h0000_0000); exec_one(0, 0,0,0, 0,0,0, 32'h0, 32'h0);        // -> 0x00
    fetch_one(0, 32'h0000_0000); exec_one(0, 0,0,0, 0,0,0, 32'h0, 32'h0);        // -> 0x04

    // Reset in FETCH with an ack in the same cycle: the instruction is dropped.
    expect_request(ok);
    reset = 1;
    imem.imem_ack = 1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("rstf_instr", Instruction, 0);
    chk("rstf_valid", instr_valid, 0);
    chk("rstf_addr",  imem.imem_addr, RESET_PC);
    chk("rstf_req",   imem.imem_req, 0);
    chk("rstf_link",  link_addr, 0);
    chk("rstf_ret",   retired_cnt, 0);
    reset = 0;
    imem.imem_ack = 0;
    #1;
    chk("rstf_req_rise", imem.imem_req, 1);
    restart_model();
    fetch_one(1, 32'h0C00_0200);

    // Reset in EXEC with jal decoded: no PC or link update.
    Jal = 1;
    reset = 1;
    @(negedge clock);
    chk("rste_addr",  imem.imem_addr, RESET_PC);
    chk("rste_link",  link_addr, 0);
    chk("rste_valid", instr_valid, 0);
    chk("rste_instr", Instruction, 0);
    clear_dec();
    reset = 0;
    restart_model();
    fetch_one(0, 32'h0000_0001); exec_one(0, 0,0,0, 0,0,0, 32'h0, 32'h0);        // -> 0x04
    expect_request(ok);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have port: clock  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Addr_Result  input  32  branch target as word address from the ALU; byte target = {Addr_Result[29:0],2'b00}.
REQ-004 SHALL have port: Zero  input  1  ALU zero flag.
REQ-005 SHALL have port: Read_data_1  input  32  rs value, the jr target.
REQ-006 SHALL have ports: Branch, nBranch, Jmp, Jal, Jr  input  1 each  controller decode of current Instruction.
REQ-007 SHALL have port: stall  input  1  holds current instruction in EXEC.
REQ-008 SHALL have ports: imem_req  output  1;  imem_addr  output  32;  imem_ack  input  1;  imem_rdata  input  32  instruction-memory handshake.
REQ-009 SHALL have ports: Instruction  output  32;  instr_valid  output  1;  PC_plus_4  output  32;  link_addr  output  32;  retired_cnt  output  32.

Function
REQ-010 SHALL implement two states: FETCH (imem_req=1, imem_addr=PC) and EXEC (instr_valid=1, Instruction held).
REQ-011 In FETCH, imem_req and imem_addr SHALL stay constant until imem_ack is sampled high; on that edge Instruction<=imem_rdata and state<=EXEC.
REQ-012 imem_ack outside FETCH SHALL be ignored.
REQ-013 Minimum latency SHALL be 2 cycles per instruction: one FETCH cycle with same-cycle ack, plus one EXEC cycle.
REQ-014 In EXEC with stall=1: state, PC, Instruction, instr_valid SHALL remain unchanged.
REQ-015 In EXEC with stall=0: PC<=next_pc and state<=FETCH; instr_valid deasserts next cycle.
REQ-016 PC_plus_4 SHALL equal PC+4 combinationally, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-017 next_pc priority SHALL be:
- Jr: {Read_data_1[31:2],2'b00}
- Jmp or Jal: {PC_plus_4[31:28],Instruction[25:0],2'b00}
- taken branch, (Branch&Zero)|(nBranch&~Zero): {Addr_Result[29:0],2'b00}
- else PC_plus_4.
REQ-018 On leaving EXEC with Jal=1, link_addr SHALL load PC_plus_4; otherwise link_addr SHALL hold.
REQ-019 Simultaneous Jr and Jal SHALL select the Jr target and still update link_addr (jalr behaviour).

Reset
REQ-020 With reset=1 at an edge: PC=0x00000000, state=FETCH, Instruction=0, instr_valid=0, link_addr=0, retired_cnt=0, imem_req=0 for that cycle.
REQ-021 imem_req SHALL assert on the first cycle after reset deasserts.
REQ-022 Reset during FETCH SHALL abort the pending request; a late ack SHALL be treated per REQ-011 only after re-entry to FETCH.
REQ-023 Reset during EXEC SHALL discard the instruction with no PC or link update.

Configuration
REQ-024 With macro IFETCH_PERF_EN defined: retired_cnt SHALL increment by 1 on each EXEC->FETCH transition and wrap at 2^32.
REQ-025 Without IFETCH_PERF_EN: retired_cnt SHALL be tied to 0 and no counter register is synthesized.

Structure
REQ-026 Shared package ifetch_pkg SHALL hold the state enum (FETCH, EXEC), RESET_PC=32'h0000_0000, and PC_STEP=4.
REQ-027 Next-PC selection SHALL be a combinational sub-module pc_next_sel; ifetch_unit holds all registers and the FSM.

Verification
REQ-028 Reset, then ack after 3 wait cycles with rdata=0x20080005 -> imem_addr=0 held 4 cycles, Instruction=0x20080005, instr_valid=1 one cycle later.
REQ-029 PC=0x10, Branch=1, Zero=1, Addr_Result=0x00000009 -> next imem_addr=0x24; same with Zero=0 -> 0x14.
REQ-030 PC=0x40, Jal=1, Instruction[25:0]=0x0000100 -> next imem_addr=0x400, link_addr=0x44.
REQ-031 Jr=1, Read_data_1=0x0000_0123 -> next imem_addr=0x120; stall=1 for 5 cycles beforehand -> PC and Instruction unchanged throughout.
REQ-032 PC=0xFFFFFFFC, no branch -> next imem_addr=0x00000000; reset asserted mid-FETCH with ack arriving the same cycle -> Instruction=0, PC=0.
REQ-033 IFETCH_PERF_EN build, 10 instructions retired -> retired_cnt=10; build without the macro -> retired_cnt=0.
